// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: default widths,
// settle length, controller states and counter slot indices.
package conv_pkg;

    localparam int CONV_DATA_W     = 8;
    localparam int CONV_ACC_W      = 16;
    localparam int CONV_DIM_W      = 4;
    localparam int CONV_SETTLE_CYC = 2;

    // Slots of the 2-D counter bank inside the sequencer
    localparam int CNT_LOAD = 0;   // engine write address during loads
    localparam int CNT_WIN  = 1;   // window origin (i, j)
    localparam int CNT_TAP  = 2;   // kernel tap (k, l)
    localparam int NUM_CNT  = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_IMG = 3'd1,
        ST_LOAD_KER = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_COMPUTE  = 3'd4,
        ST_CAPTURE  = 3'd5,
        ST_EMIT     = 3'd6,
        ST_FINISH   = 3'd7
    } conv_state_t;

endpackage

// File: rtl/conv_idx2d.sv
// Row-major 2-D index counter. Column wraps at col_max and bumps the row;
// the row wraps at row_max, so the counter returns to (0,0) after the last
// position and is ready for the next pass without an explicit clear.
module conv_idx2d #(
    parameter int DIM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIM_W-1:0] row_max,
    input  logic [DIM_W-1:0] col_max,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last
);

    logic [DIM_W-1:0] row_reg;
    logic [DIM_W-1:0] col_reg;
    logic             col_wrap;
    logic             row_wrap;

    assign col_wrap = (col_reg == col_max);
    assign row_wrap = (row_reg == row_max);

    // Advance one position per enable, wrapping column then row
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (en) begin
            if (col_wrap) begin
                col_reg <= '0;
                row_reg <= row_wrap ? '0 : row_reg + DIM_W'(1);
            end else begin
                col_reg <= col_reg + DIM_W'(1);
            end
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = col_wrap && row_wrap;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution job sequencer: loads image and kernel into the engine,
// walks every window and tap, captures one result per window and hands
// it out on a valid/ready stream.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_W     = CONV_DATA_W,
    parameter int ACC_W      = CONV_ACC_W,
    parameter int DIM_W      = CONV_DIM_W,
    parameter int SETTLE_CYC = CONV_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_in_row,
    input  logic [DIM_W-1:0]  cfg_in_col,
    input  logic [DIM_W-1:0]  cfg_ker_row,
    input  logic [DIM_W-1:0]  cfg_ker_col,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              eng_img_we,
    output logic              eng_ker_we,
    output logic [DATA_W-1:0] eng_wdata,
    output logic [DIM_W-1:0]  eng_wrow,
    output logic [DIM_W-1:0]  eng_wcol,
    output logic [DIM_W-1:0]  eng_win_i,
    output logic [DIM_W-1:0]  eng_win_j,
    output logic [DIM_W-1:0]  eng_tap_k,
    output logic [DIM_W-1:0]  eng_tap_l,
    output logic              eng_acc_clr,
    output logic              eng_acc_en,
    input  logic [ACC_W-1:0]  eng_result,
    output logic [ACC_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    conv_state_t state_reg, state_next;

    logic [DIM_W-1:0] in_row_reg, in_col_reg, ker_row_reg, ker_col_reg;
    logic [SW-1:0]    settle_cnt_reg;
    logic [ACC_W-1:0] m_data_reg;
    logic             err_reg;
    logic             cfg_ok;
    logic             settle_done;

    logic [NUM_CNT-1:0] cnt_clr;
    logic [NUM_CNT-1:0] cnt_en;
    logic [NUM_CNT-1:0] cnt_last;
    logic [DIM_W-1:0]   cnt_row_max [NUM_CNT];
    logic [DIM_W-1:0]   cnt_col_max [NUM_CNT];
    logic [DIM_W-1:0]   cnt_row     [NUM_CNT];
    logic [DIM_W-1:0]   cnt_col     [NUM_CNT];

    // Bounds are max indices, so "kernel fits" is a plain <= compare
    assign cfg_ok      = (cfg_ker_row <= cfg_in_row) && (cfg_ker_col <= cfg_in_col);
    assign settle_done = (settle_cnt_reg == SW'(SETTLE_CYC - 1));

    // Counter bank: load address, window origin, kernel tap
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            conv_idx2d #(.DIM_W(DIM_W)) u_idx (
                .clk     (clk),
                .rst     (rst),
                .clr     (cnt_clr[gi]),
                .en      (cnt_en[gi]),
                .row_max (cnt_row_max[gi]),
                .col_max (cnt_col_max[gi]),
                .row     (cnt_row[gi]),
                .col     (cnt_col[gi]),
                .last    (cnt_last[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch job dimensions when a start is accepted in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            in_row_reg  <= '0;
            in_col_reg  <= '0;
            ker_row_reg <= '0;
            ker_col_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            in_row_reg  <= cfg_in_row;
            in_col_reg  <= cfg_in_col;
            ker_row_reg <= cfg_ker_row;
            ker_col_reg <= cfg_ker_col;
        end
    end

    // One-cycle error pulse for a kernel that does not fit the image
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_reg == ST_IDLE) && start && !cfg_ok;
        end
    end

    // Count cycles spent in SETTLE; held at zero elsewhere
    always_ff @(posedge clk) begin
        if (rst || state_reg != ST_SETTLE) begin
            settle_cnt_reg <= '0;
        end else begin
            settle_cnt_reg <= settle_cnt_reg + SW'(1);
        end
    end

    // Capture the engine accumulator one cycle after the last tap
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_reg <= '0;
        end else if (state_reg == ST_CAPTURE) begin
            m_data_reg <= eng_result;
        end
    end

    // Next-state, counter control and strobe decode
    always_comb begin
        state_next  = state_reg;
        s_ready     = 1'b0;
        eng_img_we  = 1'b0;
        eng_ker_we  = 1'b0;
        eng_acc_en  = 1'b0;
        eng_acc_clr = 1'b0;
        m_valid     = 1'b0;
        done        = 1'b0;
        cnt_clr     = '0;
        cnt_en      = '0;

        cnt_row_max[CNT_LOAD] = in_row_reg;
        cnt_col_max[CNT_LOAD] = in_col_reg;
        cnt_row_max[CNT_WIN]  = in_row_reg - ker_row_reg;
        cnt_col_max[CNT_WIN]  = in_col_reg - ker_col_reg;
        cnt_row_max[CNT_TAP]  = ker_row_reg;
        cnt_col_max[CNT_TAP]  = ker_col_reg;

        case (state_reg)
            ST_IDLE: begin
                cnt_clr = '1;
                if (start && cfg_ok) begin
                    state_next = ST_LOAD_IMG;
                end
            end
            ST_LOAD_IMG: begin
                s_ready          = 1'b1;
                eng_img_we       = s_valid;
                cnt_en[CNT_LOAD] = s_valid;
                if (s_valid && cnt_last[CNT_LOAD]) begin
                    state_next = ST_LOAD_KER;
                end
            end
            ST_LOAD_KER: begin
                // Load counter wrapped to (0,0) at the end of the image
                cnt_row_max[CNT_LOAD] = ker_row_reg;
                cnt_col_max[CNT_LOAD] = ker_col_reg;
                s_ready               = 1'b1;
                eng_ker_we            = s_valid;
                cnt_en[CNT_LOAD]      = s_valid;
                if (s_valid && cnt_last[CNT_LOAD]) begin
                    state_next = (SETTLE_CYC > 0) ? ST_SETTLE : ST_COMPUTE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                eng_acc_en      = 1'b1;
                eng_acc_clr     = (cnt_row[CNT_TAP] == '0) && (cnt_col[CNT_TAP] == '0);
                cnt_en[CNT_TAP] = 1'b1;
                if (cnt_last[CNT_TAP]) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_EMIT;
            end
            ST_EMIT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    cnt_en[CNT_WIN] = 1'b1;
                    state_next      = cnt_last[CNT_WIN] ? ST_FINISH : ST_COMPUTE;
                end
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Data is only driven onto the engine bus during a write beat
    assign eng_wdata = (eng_img_we || eng_ker_we) ? s_data : '0;
    assign eng_wrow  = cnt_row[CNT_LOAD];
    assign eng_wcol  = cnt_col[CNT_LOAD];
    assign eng_win_i = cnt_row[CNT_WIN];
    assign eng_win_j = cnt_col[CNT_WIN];
    assign eng_tap_k = cnt_row[CNT_TAP];
    assign eng_tap_l = cnt_col[CNT_TAP];
    assign m_data    = m_data_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign err       = err_reg;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: behavioural engine plus a direct
// convolution reference computed from the job's image and kernel.
module tb_conv_seq_ctrl;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int DIM_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  cfg_in_row = '0, cfg_in_col = '0, cfg_ker_row = '0, cfg_ker_col = '0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              eng_img_we, eng_ker_we;
    logic [DATA_W-1:0] eng_wdata;
    logic [DIM_W-1:0]  eng_wrow, eng_wcol, eng_win_i, eng_win_j, eng_tap_k, eng_tap_l;
    logic              eng_acc_clr, eng_acc_en;
    logic [ACC_W-1:0]  eng_result;
    logic [ACC_W-1:0]  m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              busy, done, err;

    conv_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_in_row(cfg_in_row), .cfg_in_col(cfg_in_col),
        .cfg_ker_row(cfg_ker_row), .cfg_ker_col(cfg_ker_col),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .eng_img_we(eng_img_we), .eng_ker_we(eng_ker_we), .eng_wdata(eng_wdata),
        .eng_wrow(eng_wrow), .eng_wcol(eng_wcol),
        .eng_win_i(eng_win_i), .eng_win_j(eng_win_j),
        .eng_tap_k(eng_tap_k), .eng_tap_l(eng_tap_l),
        .eng_acc_clr(eng_acc_clr), .eng_acc_en(eng_acc_en), .eng_result(eng_result),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural convolution engine
    logic [DATA_W-1:0] eimg [16][16];
    logic [DATA_W-1:0] eker [16][16];
    logic [ACC_W-1:0]  eacc = '0;

    always @(posedge clk) begin
        if (eng_img_we) eimg[eng_wrow][eng_wcol] <= eng_wdata;
        if (eng_ker_we) eker[eng_wrow][eng_wcol] <= eng_wdata;
        if (eng_acc_en)
            eacc <= (eng_acc_clr ? '0 : eacc)
                  + ACC_W'(eimg[eng_win_i + eng_tap_k][eng_win_j + eng_tap_l])
                  * ACC_W'(eker[eng_tap_k][eng_tap_l]);
    end
    assign eng_result = eacc;

    // Bookkeeping
    int n_vec = 0;
    int n_bad = 0;
    int img_m [16][16];
    int ker_m [16][16];
    int stream [$];
    int exp_wr [$];
    int exp_wd [$];
    int exp_res [$];
    int got_res [$];
    int nom_res [$];
    int img_cnt, ker_cnt, acc_cnt, done_cnt, err_cnt;
    bit bp_mode = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    bit               hold_prev = 1'b0;
    logic [ACC_W-1:0] prev_data;
    logic [DIM_W-1:0] prev_i, prev_j;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (eng_img_we || eng_ker_we) begin
                if (eng_img_we) img_cnt++;
                if (eng_ker_we) ker_cnt++;
                if (exp_wr.size() == 0) begin
                    check_val("wr_extra", 1, 0);
                end else begin
                    check_val("wr_addr", {eng_img_we, eng_ker_we, eng_wrow, eng_wcol}, exp_wr.pop_front());
                    check_val("wr_data", eng_wdata, exp_wd.pop_front());
                end
            end
            if (eng_acc_en) acc_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (m_valid && hold_prev) begin
                check_val("m_hold", m_data, prev_data);
                check_val("win_hold", {eng_win_i, eng_win_j}, {prev_i, prev_j});
            end
            if (m_valid && m_ready) begin
                got_res.push_back(int'(m_data));
                if (exp_res.size() == 0) check_val("res_extra", 1, 0);
                else check_val("result", m_data, exp_res.pop_front());
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_i    = eng_win_i;
            prev_j    = eng_win_j;
        end
    end

    // Result-side ready: always high, or random when backpressure is on
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Build data, expected write stream and reference results for one job
    task automatic prep_job(input int ir, input int ic, input int kr, input int kc, input int mode);
        int sum;
        stream.delete(); exp_wr.delete(); exp_wd.delete(); exp_res.delete(); got_res.delete();
        img_cnt = 0; ker_cnt = 0; acc_cnt = 0; done_cnt = 0; err_cnt = 0;
        for (int r = 0; r <= ir; r++)
            for (int c = 0; c <= ic; c++) begin
                if (mode == 0) img_m[r][c] = (r == 0 && c < 2) ? 1 - c : r * 5 + c;
                else           img_m[r][c] = int'($urandom_range(0, 255));
                stream.push_back(img_m[r][c]);
                exp_wr.push_back((2 << 8) | (r << 4) | c);
                exp_wd.push_back(img_m[r][c]);
            end
        for (int k = 0; k <= kr; k++)
            for (int l = 0; l <= kc; l++) begin
                if (mode == 0)      ker_m[k][l] = ((k + l) % 2 == 0) ? 1 : 0;
                else if (mode == 2) ker_m[k][l] = 1;
                else                ker_m[k][l] = int'($urandom_range(0, 255));
                stream.push_back(ker_m[k][l]);
                exp_wr.push_back((1 << 8) | (k << 4) | l);
                exp_wd.push_back(ker_m[k][l]);
            end
        for (int i = 0; i <= ir - kr; i++)
            for (int j = 0; j <= ic - kc; j++) begin
                sum = 0;
                for (int k = 0; k <= kr; k++)
                    for (int l = 0; l <= kc; l++)
                        sum += img_m[i + k][j + l] * ker_m[k][l];
                exp_res.push_back(sum & 16'hFFFF);
            end
    endtask

    task automatic start_job(input int ir, input int ic, input int kr, input int kc);
        cfg_in_row  = DIM_W'(ir);
        cfg_in_col  = DIM_W'(ic);
        cfg_ker_row = DIM_W'(kr);
        cfg_ker_col = DIM_W'(kc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input bit stall);
        int idx = 0;
        int cyc = 0;
        bit hs;
        while (idx < stream.size() && cyc < 3 * stream.size() + 20) begin
            s_valid = !(stall && (cyc % 3 == 2));
            s_data  = DATA_W'(stream[idx]);
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        check_val("feed_done", idx, stream.size());
    endtask

    task automatic run_job(input int ir, input int ic, input int kr, input int kc,
                           input int mode, input bit stall, input bit bp);
        int nwin, budget, n;
        nwin   = (ir - kr + 1) * (ic - kc + 1);
        budget = nwin * ((kr + 1) * (kc + 1) + 2) * 4 + 100;
        bp_mode = bp;
        prep_job(ir, ic, kr, kc, mode);
        start_job(ir, ic, kr, kc);
        feed(stall);
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_val("done_pulses", done_cnt, 1);
        check_val("n_results", got_res.size(), nwin);
        check_val("img_we_cnt", img_cnt, (ir + 1) * (ic + 1));
        check_val("ker_we_cnt", ker_cnt, (kr + 1) * (kc + 1));
        check_val("acc_en_cnt", acc_cnt, nwin * (kr + 1) * (kc + 1));
        check_val("busy_end", busy, 0);
        bp_mode = 1'b0;
        $display("job img %0dx%0d ker %0dx%0d stall=%0d bp=%0d: %0d results",
                 ir + 1, ic + 1, kr + 1, kc + 1, stall, bp, got_res.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctrl"}, {s_ready, eng_img_we, eng_ker_we, eng_acc_clr, eng_acc_en,
                                   m_valid, busy, done, err}, 0);
        check_val({tag, "_data"}, {eng_wdata, eng_wrow, eng_wcol, eng_win_i, eng_win_j,
                                   eng_tap_k, eng_tap_l, m_data}, 0);
    endtask

    initial begin
        bit busy_seen;
        int n, ir, ic, kr, kc;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal 5x5 / 3x3
        run_job(4, 4, 2, 2, 0, 1'b0, 1'b0);
        check_val("nom_r0", got_res.size() > 0 ? got_res[0] : -1, 31);
        check_val("nom_r1", got_res.size() > 1 ? got_res[1] : -1, 34);
        nom_res = got_res;

        // Same job under random backpressure
        run_job(4, 4, 2, 2, 0, 1'b0, 1'b1);
        for (int i = 0; i < nom_res.size(); i++)
            check_val("bp_same", i < got_res.size() ? got_res[i] : -1, nom_res[i]);

        // Input stalls every third cycle
        run_job(4, 4, 2, 2, 0, 1'b1, 1'b0);

        // Illegal config: kernel taller than image
        prep_job(0, 0, 0, 0, 1);
        stream.delete(); exp_wr.delete(); exp_wd.delete(); exp_res.delete();
        start_job(4, 4, 5, 2);
        busy_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            busy_seen |= busy;
            @(posedge clk);
        end
        #1;
        check_val("ill_err", err_cnt, 1);
        check_val("ill_busy", busy_seen, 0);
        check_val("ill_strobes", img_cnt + ker_cnt + acc_cnt, 0);
        $display("job illegal ker 6 rows on 5-row image: err pulses %0d", err_cnt);

        // Edge sizes
        run_job(15, 15, 0, 0, 2, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++)
            check_val("k1_pass", i < got_res.size() ? got_res[i] : -1, img_m[i / 16][i % 16]);
        run_job(15, 15, 15, 15, 1, 1'b0, 1'b0);

        // Reset during COMPUTE, then a fresh job
        prep_job(5, 5, 1, 1, 1);
        start_job(5, 5, 1, 1);
        feed(1'b0);
        n = 0;
        while (!eng_acc_en && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("reach_compute", eng_acc_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        $display("job reset mid-compute after %0d acc_en cycles", acc_cnt);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_job(5, 4, 2, 1, 1, 1'b0, 1'b0);

        // Random jobs
        for (int t = 0; t < 3; t++) begin
            ir = int'($urandom_range(0, 7));
            ic = int'($urandom_range(0, 7));
            kr = int'($urandom_range(0, ir));
            kc = int'($urandom_range(0, ic));
            run_job(ir, ic, kr, kc, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
